// File: rtl/z80_bus_master_pkg.sv
// Shared definitions for the Z80 bus-cycle generator: op codes, half-T-state
// encoding and the refresh address layout.
package z80_bus_master_pkg;

  localparam logic [1:0] OP_M1 = 2'd0;
  localparam logic [1:0] OP_WR = 2'd2;

  // One state per half T-state; H is the first clk of a T-state, L the second.
  typedef enum logic [3:0] {
    S_IDLE,
    S_T1H, S_T1L,
    S_T2H, S_T2L,
    S_TWH, S_TWL,
    S_T3H, S_T3L,
    S_T4H, S_T4L
  } bus_state_e;

  // Refresh address: I register on the high byte, bit 7 always clear.
  function automatic logic [15:0] rfsh_addr(input logic [7:0] i, input logic [6:0] r);
    return {i, 1'b0, r};
  endfunction

endpackage

// File: rtl/z80_bus_master_refresh_counter.sv
// 7-bit Z80 R-register counter; advances once per completed opcode fetch.
module refresh_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [6:0] r
);

  always_ff @(posedge clk) begin
    if (rst)      r <= '0;
    else if (inc) r <= r + 7'd1;
  end

endmodule

// File: rtl/z80_bus_master.sv
// Cycle-accurate Z80 opcode-fetch / memory-read / memory-write bus master,
// clocked at twice the Z80 clock so each clk is half a T-state.
module z80_bus_master
  import z80_bus_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [7:0]  i_reg,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  input  logic        nwait,
  input  logic [7:0]  din,
  output logic [15:0] a,
  output logic [7:0]  dout,
  output logic        doe,
  output logic        nmreq,
  output logic        nrd,
  output logic        nwr,
  output logic        nm1,
  output logic        nrfshd
);

  bus_state_e st;
  logic       is_m1, is_wr;
  logic [7:0] wdata_q;
  logic [6:0] rcnt;
  logic [2:0] vld_pipe;
  logic       cyc_end, accept, m1_cap, rd_cap;

  assign cyc_end    = (st == S_T4L) || (st == S_T3L && !is_m1);
  assign req_ready  = (st == S_IDLE) || cyc_end;
  assign accept     = req_valid && req_ready;
  assign m1_cap     = is_m1 && nwait && (st == S_T2L || st == S_TWL);
  assign rd_cap     = !is_m1 && !is_wr && (st == S_T3H);
  assign resp_valid = vld_pipe[2];

  refresh_counter u_rfsh (
    .clk (clk),
    .rst (rst),
    .inc (st == S_T4L),
    .r   (rcnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      a          <= '0;
      dout       <= '0;
      doe        <= 1'b0;
      nmreq      <= 1'b1;
      nrd        <= 1'b1;
      nwr        <= 1'b1;
      nm1        <= 1'b1;
      nrfshd     <= 1'b1;
      is_m1      <= 1'b0;
      is_wr      <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      vld_pipe   <= '0;
    end else begin
      // Fetch data reaches resp_valid one clk after capture; read data is
      // held back one extra clk so read latency stays fetch latency + 2.
      vld_pipe <= {vld_pipe[1], vld_pipe[0] | m1_cap, rd_cap};
      if (m1_cap || rd_cap) resp_rdata <= din;

      if (st == S_IDLE || cyc_end) begin
        // Cycle boundary: releases refresh and the data bus, whether the
        // next step is IDLE or a back-to-back T1H.
        nmreq  <= 1'b1;
        nrd    <= 1'b1;
        nwr    <= 1'b1;
        nm1    <= 1'b1;
        nrfshd <= 1'b1;
        doe    <= 1'b0;
        st     <= S_IDLE;
        if (accept) begin
          st      <= S_T1H;
          a       <= req_addr;
          is_m1   <= (req_op == OP_M1);
          is_wr   <= (req_op == OP_WR);
          wdata_q <= req_wdata;
          nm1     <= (req_op != OP_M1);
        end
      end else begin
        case (st)
          S_T1H: begin
            st    <= S_T1L;
            nmreq <= 1'b0;
            nrd   <= is_wr;
            if (is_wr) begin
              dout <= wdata_q;
              doe  <= 1'b1;
            end
          end
          S_T1L: st <= S_T2H;
          S_T2H: begin
            st <= S_T2L;
            if (is_wr) nwr <= 1'b0;
          end
          S_T2L, S_TWL: begin
            if (!nwait) st <= S_TWH;
            else begin
              st <= S_T3H;
              if (is_m1) begin
                nmreq  <= 1'b1;
                nrd    <= 1'b1;
                nm1    <= 1'b1;
                nrfshd <= 1'b0;
                a      <= rfsh_addr(i_reg, rcnt);
              end
            end
          end
          S_TWH: st <= S_TWL;
          S_T3H: begin
            st <= S_T3L;
            if (is_m1) nmreq <= 1'b0;
            else begin
              nmreq <= 1'b1;
              nrd   <= 1'b1;
              nwr   <= 1'b1;
            end
          end
          S_T3L: st <= S_T4H;
          S_T4H: begin
            st    <= S_T4L;
            nmreq <= 1'b1;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: a half-T-state timeline model checked every clk,
// plus directed transactions with hand-computed literal expectations.
module tb_z80_bus_master;

  localparam logic [1:0] M1 = 2'd0, RD = 2'd1, WR = 2'd2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0, i_reg = '0;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        nwait = 1'b1;
  logic [7:0]  din;
  logic [15:0] a;
  logic [7:0]  dout;
  logic        doe, nmreq, nrd, nwr, nm1, nrfshd;
  logic        din_ovr_en = 1'b0;
  logic [7:0]  din_ovr = '0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] ad);
    return ad[7:0] ^ ad[15:8] ^ 8'h5A;
  endfunction

  assign din = din_ovr_en ? din_ovr : mem(a);

  z80_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .i_reg(i_reg),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .nwait(nwait), .din(din),
    .a(a), .dout(dout), .doe(doe), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
    .nm1(nm1), .nrfshd(nrfshd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { logic [1:0] op; logic [15:0] addr; logic [7:0] wdata; int w; } txn_t;
  typedef struct { int t; logic [7:0] d; } rsp_t;

  txn_t        txq[$];
  rsp_t        rq[$];
  txn_t        cur;
  rsp_t        nr;
  int          acc_cnt = 0, hc = 0, m_p = 0, m_r = 0, L, q;
  bit          started = 0, m_act = 0, is_f, is_w;
  logic [15:0] m_a = '0, e_a;
  logic [7:0]  m_dout = '0, e_do;
  logic        e_mreq, e_rd, e_wr, e_m1, e_rf, e_doe, e_rdy, e_rv;

  // Outputs are judged by position p within the bus cycle (p=0 is T1H);
  // wait halves repeat the T2L picture, so q folds them away.
  initial begin
    cur.op = RD; cur.addr = '0; cur.wdata = '0; cur.w = 0;
    forever begin
      @(negedge clk);
      e_mreq = 1; e_rd = 1; e_wr = 1; e_m1 = 1; e_rf = 1; e_doe = 0; e_rdy = 1;
      e_a = m_a; e_do = m_dout;
      is_f = (cur.op == M1);
      is_w = (cur.op == WR);
      L = (is_f ? 8 : 6) + 2 * cur.w;
      if (m_act) begin
        q = (m_p < 4) ? m_p : ((m_p < 4 + 2 * cur.w) ? 3 : m_p - 2 * cur.w);
        e_rdy = (m_p == L - 1);
        if (is_f) begin
          e_m1   = !(q <= 3);
          e_mreq = !(q inside {1, 2, 3, 5, 6});
          e_rd   = !(q >= 1 && q <= 3);
          e_rf   = !(q >= 4);
          e_a    = (q < 4) ? cur.addr : {i_reg, 1'b0, 7'(m_r)};
        end else begin
          e_a    = cur.addr;
          e_mreq = !(q >= 1 && q <= 4);
          if (is_w) begin
            e_wr  = !(q == 3 || q == 4);
            e_doe = (q >= 1 && q <= 5);
            if (q >= 1) e_do = cur.wdata;
          end else e_rd = !(q >= 1 && q <= 4);
        end
      end
      e_rv = (rq.size() > 0) && (rq[0].t == hc);
      if (started) begin
        chk("nmreq", nmreq, e_mreq);  chk("nrd", nrd, e_rd);
        chk("nwr", nwr, e_wr);        chk("nm1", nm1, e_m1);
        chk("nrfshd", nrfshd, e_rf);  chk("a", a, e_a);
        chk("doe", doe, e_doe);       chk("dout", dout, e_do);
        chk("req_ready", req_ready, e_rdy);
        chk("resp_valid", resp_valid, e_rv);
        if (e_rv) chk("resp_rdata", resp_rdata, rq[0].d);
      end
      if (e_rv) void'(rq.pop_front());
      m_a = e_a; m_dout = e_do;

      // Drive WAIT: scripted at T2L/TWL sample points, noise elsewhere.
      if (m_act && m_p >= 3 && m_p <= 3 + 2 * cur.w && ((m_p - 3) % 2 == 0))
        nwait = ((m_p - 3) / 2 < cur.w) ? 1'b0 : 1'b1;
      else
        nwait = (hc % 3 == 0) ? 1'b0 : 1'b1;

      if (rst) begin
        m_act = 0; m_r = 0; m_a = '0; m_dout = '0; rq.delete(); started = 1;
      end else begin
        if (m_act) begin
          if (m_p == L - 1) begin
            m_act = 0;
            if (is_f) m_r = (m_r + 1) % 128;
          end else m_p++;
        end
        if (started && e_rdy && req_valid && txq.size() > 0) begin
          cur = txq.pop_front();
          m_act = 1; m_p = 0; acc_cnt++;
          if (cur.op != WR) begin
            nr.t = hc + 1 + ((cur.op == M1) ? 5 : 7) + 2 * cur.w;
            nr.d = din_ovr_en ? din_ovr : mem(cur.addr);
            rq.push_back(nr);
          end
        end
      end
      hc++;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] op, input logic [15:0] ad, input logic [7:0] wd, input int w);
    txn_t t;
    int   c0;
    t.op = op; t.addr = ad; t.wdata = wd; t.w = w;
    txq.push_back(t);
    c0 = acc_cnt;
    req_valid = 1'b1; req_op = op; req_addr = ad; req_wdata = wd;
    for (int k = 0; k < 100 && acc_cnt == c0; k++) begin
      @(posedge clk); #1;
    end
    chk("accepted", (acc_cnt != c0), 1);
    if (acc_cnt == c0) begin
      txq.delete();
      req_valid = 1'b0;
    end
  endtask

  logic [7:0] pat_mreq, pat_rd, pat_m1, pat_rf;
  int         cnt_a, cnt_b, lat, rdy_at;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_nmreq", nmreq, 1);   chk("rst_nm1", nm1, 1);
    chk("rst_a", a, 16'h0000);    chk("rst_doe", doe, 0);
    chk("rst_ready", req_ready, 1); chk("rst_resp", resp_valid, 0);
    @(posedge clk); #1;

    // Fetch 0x1234, I=0x3F: literal per-half strobe pictures.
    i_reg = 8'h3F;
    pat_mreq = 8'b1001_0001; pat_rd = 8'b1111_0001;
    pat_m1   = 8'b1111_0000; pat_rf = 8'b0000_1111;
    send(M1, 16'h1234, 8'h00, 0);
    req_valid = 1'b0;
    cnt_a = 0; lat = -1;
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      if (!nrfshd) cnt_a++;
      if (resp_valid && lat < 0) begin
        lat = h;
        chk("f_rdata", resp_rdata, 8'h7C);
      end
      if (h < 8) begin
        chk("f_nmreq", nmreq, pat_mreq[h]);
        chk("f_nrd", nrd, pat_rd[h]);
        chk("f_nm1", nm1, pat_m1[h]);
        chk("f_nrfshd", nrfshd, pat_rf[h]);
        chk("f_a", a, (h < 4) ? 16'h1234 : 16'h3F00);
      end
    end
    chk("f_rfsh_len", cnt_a, 4);
    chk("f_latency", lat, 5);

    // Read 0x8000, data 0xA5.
    @(posedge clk); #1;
    din_ovr_en = 1'b1; din_ovr = 8'hA5;
    send(RD, 16'h8000, 8'h00, 0);
    req_valid = 1'b0;
    lat = -1; rdy_at = -1;
    for (int h = 0; h < 12; h++) begin
      @(negedge clk);
      if (req_ready && rdy_at < 0) rdy_at = h;
      if (resp_valid && lat < 0) begin
        lat = h;
        chk("rd_rdata", resp_rdata, 8'hA5);
      end
    end
    chk("rd_latency", lat, 7);
    chk("rd_len", rdy_at + 1, 6);
    din_ovr_en = 1'b0;

    // Write 0x55 to 0xC000 with two WAIT samples.
    @(posedge clk); #1;
    send(WR, 16'hC000, 8'h55, 2);
    req_valid = 1'b0;
    cnt_a = 0; cnt_b = 0; rdy_at = -1;
    for (int h = 0; h < 14; h++) begin
      @(negedge clk);
      if (!nwr) cnt_a++;
      if (doe) begin
        cnt_b++;
        chk("wr_dout", dout, 8'h55);
      end
      if (req_ready && rdy_at < 0) rdy_at = h;
    end
    chk("wr_nwr_len", cnt_a, 6);
    chk("wr_doe_len", cnt_b, 9);
    chk("wr_len", rdy_at + 1, 10);

    // Reset during T2L of a read: response must be dropped.
    @(posedge clk); #1;
    din_ovr_en = 1'b1; din_ovr = 8'h3C;
    send(RD, 16'h8000, 8'h00, 0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_nmreq", nmreq, 1); chk("mr_nrd", nrd, 1);
    chk("mr_doe", doe, 0);     chk("mr_ready", req_ready, 1);
    cnt_a = 0;
    for (int h = 0; h < 12; h++) begin
      @(negedge clk);
      if (resp_valid) cnt_a++;
    end
    chk("mr_no_resp", cnt_a, 0);
    din_ovr_en = 1'b0;

    // Reserved op behaves as a read.
    @(posedge clk); #1;
    send(2'd3, 16'h00FF, 8'h00, 0);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // 130 back-to-back fetches; R wraps at fetch 128.
    i_reg = 8'h81;
    for (int k = 0; k < 130; k++) begin
      send(M1, 16'h0200 + 16'(k) * 16'h0101, 8'h00, (k == 40) ? 1 : 0);
      if (k == 127 || k == 128) begin
        repeat (5) @(negedge clk);
        chk((k == 127) ? "rfsh_127" : "rfsh_wrap", a, (k == 127) ? 16'h817F : 16'h8100);
        @(posedge clk); #1;
      end
    end

    // Fetch directly followed by a write.
    send(WR, 16'h4000, 8'hC3, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("fw_nrfshd", nrfshd, 1);
    chk("fw_a", a, 16'h4000);
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
